// File: rtl/riscv_wb_pkg.sv
// Shared definitions for the RISC-V writeback stage: FSM encoding, load
// funct3 codes and the default load-response timeout.
package riscv_wb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load extractor: picks the byte/halfword/word addressed by
// offset out of an aligned memory word and flags misaligned or illegal loads.
module riscv_load_align
  import riscv_wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    data     = 32'd0;
    err      = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'd0, byte_sel};
      F3_LH: begin
        data = {{16{half_sel[15]}}, half_sel};
        err  = offset[0];
      end
      F3_LHU: begin
        data = {16'd0, half_sel};
        err  = offset[0];
      end
      F3_LW: begin
        data = rdata;
        err  = (offset != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_writeback.sv
// Writeback stage: accepts one instruction at a time, waits for load data
// with a bounded timeout, and issues a single-cycle register-file write.
// Optional bypass outputs are enabled by defining RISCV_WB_FWD_EN.
module riscv_writeback
  import riscv_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [4:0]            ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic                  ex_is_load,
  input  logic                  ex_wen,
  input  logic [2:0]            ex_funct3,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  reg_wen,
  output logic [4:0]            addr_d,
  output logic [DATA_WIDTH-1:0] data_d,
  output logic                  wb_err,
  output logic                  busy,
  output logic                  fwd_valid,
  output logic [4:0]            fwd_addr,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  // The counter holds the number of WAIT_MEM cycles already spent, so the
  // TIMEOUT-th waiting cycle is the last one in which mem_rvalid is honoured.
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  wb_state_t   state;
  logic [3:0]  wait_cnt;
  logic [4:0]  rd_q;
  logic [1:0]  offset_q;
  logic [2:0]  funct3_q;
  logic        wen_q;
  logic [31:0] load_data;
  logic        load_err;

  riscv_load_align u_align (
    .funct3 (funct3_q),
    .offset (offset_q),
    .rdata  (mem_rdata),
    .data   (load_data),
    .err    (load_err)
  );

  assign ex_ready = reset && (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      rd_q     <= 5'd0;
      offset_q <= 2'd0;
      funct3_q <= 3'd0;
      wen_q    <= 1'b0;
      reg_wen  <= 1'b0;
      wb_err   <= 1'b0;
      addr_d   <= 5'd0;
      data_d   <= '0;
    end else begin
      reg_wen <= 1'b0;
      wb_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            rd_q     <= ex_rd;
            offset_q <= ex_result[1:0];
            funct3_q <= ex_funct3;
            wen_q    <= ex_wen;
            if (ex_is_load) begin
              state    <= WAIT_MEM;
              wait_cnt <= 4'd0;
            end else begin
              state <= WRITE;
              // addr_d/data_d only move when a real write is issued
              if (ex_wen && (ex_rd != 5'd0)) begin
                reg_wen <= 1'b1;
                addr_d  <= ex_rd;
                data_d  <= ex_result;
              end
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            if (load_err) begin
              wb_err <= 1'b1;
              state  <= IDLE;
            end else begin
              state <= WRITE;
              if (wen_q && (rd_q != 5'd0)) begin
                reg_wen <= 1'b1;
                addr_d  <= rd_q;
                data_d  <= load_data;
              end
            end
          end else if (wait_cnt == WAIT_LAST) begin
            wb_err <= 1'b1;
            state  <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RISCV_WB_FWD_EN
  assign fwd_valid = reg_wen;
  assign fwd_addr  = addr_d;
  assign fwd_data  = data_d;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = 5'd0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_riscv_writeback.sv
// Randomized scoreboard bench for riscv_writeback: a driver issues
// instructions and pushes expected outputs, a monitor pops and compares.
module tb_riscv_writeback;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic        ex_wen;
  logic [2:0]  ex_funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        reg_wen;
  logic [4:0]  addr_d;
  logic [31:0] data_d;
  logic        wb_err;
  logic        busy;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;

  riscv_writeback #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd(ex_rd), .ex_result(ex_result), .ex_is_load(ex_is_load),
    .ex_wen(ex_wen), .ex_funct3(ex_funct3), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .reg_wen(reg_wen), .addr_d(addr_d),
    .data_d(data_d), .wb_err(wb_err), .busy(busy), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    int unsigned cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [4:0]  last_addr = 5'd0;
  logic [31:0] last_data = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference load semantics, written from the instruction-set rules.
  function automatic void model_load(input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] word, output bit err,
                                     output logic [31:0] val);
    int unsigned off = addr % 4;
    int unsigned b   = (word >> (8 * off)) & 32'hFF;
    int unsigned h   = (word >> (16 * (off / 2))) & 32'hFFFF;
    err = 1'b0;
    val = 32'd0;
    case (f3)
      3'd0: val = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: val = b;
      3'd1: begin err = (off % 2) != 0; val = (h >= 32768) ? h + 32'hFFFF_0000 : h; end
      3'd5: begin err = (off % 2) != 0; val = h; end
      3'd2: begin err = (off != 0); val = word; end
      default: err = 1'b1;
    endcase
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ex_ready && n < 40) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      n++;
    end
    mem_rvalid = 1'b0;
    if (!ex_ready) chk({tag, "_ready_timeout"}, 32'(ex_ready), 32'd1);
  endtask

  // k = WAIT_MEM cycle carrying mem_rvalid (k > TO means no response).
  task automatic issue(input bit is_load, input logic [4:0] rd, input logic [31:0] res,
                       input logic [2:0] f3, input bit wen, input int k,
                       input logic [31:0] word);
    int unsigned a;
    exp_t        e;
    bit          lerr;
    logic [31:0] lval;
    wait_ready("issue");
    ex_valid   = 1'b1;
    ex_rd      = rd;
    ex_result  = res;
    ex_is_load = is_load;
    ex_wen     = wen;
    ex_funct3  = f3;
    mem_rvalid = ($urandom % 4) == 0;  // must be ignored in IDLE
    mem_rdata  = $urandom;
    @(posedge clk); #1;
    a          = cyc;
    ex_valid   = 1'b0;
    mem_rvalid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    if (!is_load) begin
      if (wen && rd != 5'd0) begin
        e = '{is_err: 1'b0, cyc: a, addr: rd, data: res};
        sb.push_back(e);
      end
    end else begin
      model_load(f3, res, word, lerr, lval);
      if (k > TO) begin
        e = '{is_err: 1'b1, cyc: a + TO, addr: 5'd0, data: 32'd0};
        sb.push_back(e);
      end else if (lerr) begin
        e = '{is_err: 1'b1, cyc: a + k, addr: 5'd0, data: 32'd0};
        sb.push_back(e);
      end else if (wen && rd != 5'd0) begin
        e = '{is_err: 1'b0, cyc: a + k, addr: rd, data: lval};
        sb.push_back(e);
      end
      for (int i = 1; i <= ((k > TO) ? TO : k); i++) begin
        mem_rvalid = (i == k);
        mem_rdata  = (i == k) ? word : $urandom;
        @(posedge clk); #1;
      end
    end
    mem_rvalid = ($urandom % 4) == 0;  // lands in WRITE or IDLE, must be ignored
    mem_rdata  = $urandom;
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   wrote;
    wrote = 1'b0;
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_output: got none expected %s at cycle %0d",
                 sb[0].is_err ? "wb_err" : "write", sb[0].cyc);
        void'(sb.pop_front());
      end
      if (reg_wen || wb_err) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got reg_wen=%0b wb_err=%0b expected none (cycle %0d)",
                   reg_wen, wb_err, cyc);
        end else begin
          e = sb.pop_front();
          $display("txn cycle %0d: %s addr=%0d data=0x%08h", cyc,
                   e.is_err ? "err  " : "write", addr_d, data_d);
          chk("out_cycle", cyc, e.cyc);
          chk("wb_err", 32'(wb_err), 32'(e.is_err));
          chk("reg_wen", 32'(reg_wen), 32'(!e.is_err));
          if (!e.is_err) begin
            chk("addr_d", 32'(addr_d), 32'(e.addr));
            chk("data_d", data_d, e.data);
            last_addr = e.addr;
            last_data = e.data;
            wrote     = 1'b1;
          end
        end
      end
      if (!reg_wen) begin
        chk("addr_hold", 32'(addr_d), 32'(last_addr));
        chk("data_hold", data_d, last_data);
      end
`ifdef RISCV_WB_FWD_EN
      chk("fwd_valid", 32'(fwd_valid), 32'(wrote));
      chk("fwd_addr", 32'(fwd_addr), 32'(last_addr));
      chk("fwd_data", fwd_data, last_data);
`else
      chk("fwd_valid", 32'(fwd_valid), 32'd0);
      chk("fwd_addr", 32'(fwd_addr), 32'd0);
      chk("fwd_data", fwd_data, 32'd0);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ex_valid = 1'b0; ex_rd = 5'd0; ex_result = 32'd0;
    ex_is_load = 1'b0; ex_wen = 1'b0; ex_funct3 = 3'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ex_ready", 32'(ex_ready), 32'd0);
    chk("rst_reg_wen", 32'(reg_wen), 32'd0);
    chk("rst_wb_err", 32'(wb_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr_d", 32'(addr_d), 32'd0);
    chk("rst_data_d", data_d, 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(ex_ready), 32'd1);
    mon_en = 1'b1;

    // Directed cases
    issue(1'b0, 5'd5, 32'h0000_1234, 3'd0, 1'b1, 0, 32'd0);
    issue(1'b1, 5'd7, 32'h0000_1003, 3'd0, 1'b1, 2, 32'h80FF_FFFF);
    issue(1'b1, 5'd8, 32'h0000_1003, 3'd4, 1'b1, 2, 32'h80FF_FFFF);
    issue(1'b0, 5'd0, 32'hDEAD_BEEF, 3'd0, 1'b1, 0, 32'd0);
    issue(1'b1, 5'd9, 32'h0000_2000, 3'd2, 1'b1, TO + 1, 32'd0);
    issue(1'b1, 5'd10, 32'h0000_2002, 3'd2, 1'b1, 3, 32'h1234_5678);
    issue(1'b1, 5'd11, 32'h0000_2000, 3'd2, 1'b1, TO, 32'hCAFE_F00D);
    issue(1'b1, 5'd12, 32'h0000_2001, 3'd1, 1'b1, 1, 32'h1234_5678);
    issue(1'b1, 5'd13, 32'h0000_2002, 3'd1, 1'b1, 1, 32'h8765_4321);
    issue(1'b1, 5'd14, 32'h0000_2000, 3'd3, 1'b1, 1, 32'h1);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      bit          ld  = $urandom % 2;
      logic [4:0]  rd  = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
      logic [31:0] res = $urandom;
      logic [2:0]  f3  = (($urandom % 4) == 0) ? 3'($urandom) : (($urandom % 2) ? 3'd2 : 3'($urandom % 6));
      bit          wen = ($urandom % 5) != 0;
      int          k   = $urandom_range(1, TO + 2);
      issue(ld, rd, res, f3, wen, k, $urandom);
    end
    wait_ready("drain");
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);

    // Reset in the middle of a load
    mon_en     = 1'b0;
    ex_valid   = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3; ex_wen = 1'b1;
    ex_funct3  = 3'd2; ex_result = 32'h100;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wait_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #0;
    chk("ready_in_reset", 32'(ex_ready), 32'd0);
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_reg_wen", 32'(reg_wen), 32'd0);
    chk("abort_wb_err", 32'(wb_err), 32'd0);
    chk("abort_addr_d", 32'(addr_d), 32'd0);
    chk("abort_data_d", data_d, 32'd0);
    chk("abort_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("abort_fwd_data", fwd_data, 32'd0);
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("after_abort_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    chk("after_abort_reg_wen", 32'(reg_wen), 32'd0);
    chk("after_abort_wb_err", 32'(wb_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
